// File: rtl/pcie_pop_scheduler.sv
// pcie_pop_scheduler
// Two-class pop scheduler for the device-1 egress path. It picks at most one
// route FIFO (P0 or P1) to pop each cycle. P0 gets weighted priority: up to
// weight_reg consecutive P0 grants while P1 is waiting, then one P1 grant.
// Downstream almost-full backpressure and FIFO occupancy gate each class.
//
// Optional feature: define SCHED_STATS_EN to add the pop_count0/pop_count1
// accepted-pop counters and the CNT_W parameter that sizes them.
//
// Ports:
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low
//   init                synchronous return to INIT (reloads weight)
//   weight_in           P0 weight, sampled while in INIT
//   fifo_empty0/1       route FIFO empty flags
//   fifo0/1_almost_empty route FIFO holds <= 1 word
//   fifo_up0/1_almostfull downstream almost-full backpressure
//   pop_0, pop_1        registered one-cycle pop strobes (never both high)
//   valid_out, sel_out  popped data valid / source (0=FIFO0, 1=FIFO1)
//   state               FSM state (RESET=0, INIT=1, IDLE=2, ACTIVE=3)
//   idle_out            high while in IDLE
//   pop_count0/1        accepted-pop counters (SCHED_STATS_EN only)
module pcie_pop_scheduler #(
  parameter int WEIGHT_W = 4
`ifdef SCHED_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic                fifo_empty0,
  input  logic                fifo_empty1,
  input  logic                fifo0_almost_empty,
  input  logic                fifo1_almost_empty,
  input  logic                fifo_up0_almostfull,
  input  logic                fifo_up1_almostfull,
  output logic                pop_0,
  output logic                pop_1,
  output logic                valid_out,
  output logic                sel_out,
  output logic [2:0]          state,
  output logic                idle_out
`ifdef SCHED_STATS_EN
  , output logic [CNT_W-1:0]  pop_count0
  , output logic [CNT_W-1:0]  pop_count1
`endif
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WEIGHT_W-1:0] weight_reg;
  logic [WEIGHT_W-1:0] credit;
  logic [WEIGHT_W-1:0] credit_d;
  logic                elig0;
  logic                elig1;
  logic                grant0;
  logic                grant1;

  // The pop_k & almost_empty term blocks a second pop of a FIFO whose last
  // word is being popped right now, since its empty flag lags by a cycle.
  assign elig0 = !fifo_empty0 && !fifo_up0_almostfull && !(pop_0 && fifo0_almost_empty);
  assign elig1 = !fifo_empty1 && !fifo_up1_almostfull && !(pop_1 && fifo1_almost_empty);

  // Next-state and arbitration. credit counts consecutive P0 grants taken
  // while P1 was also eligible; it only increments below weight_reg, so it
  // saturates there and never wraps.
  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    grant0   = 1'b0;
    grant1   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        credit_d = '0;
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (init) begin
          state_d  = ST_INIT;
          credit_d = '0;
        end else begin
          if (elig0 && elig1) begin
            if (weight_reg == '0) begin
              grant0 = 1'b1;
            end else if (credit < weight_reg) begin
              grant0   = 1'b1;
              credit_d = credit + WEIGHT_W'(1);
            end else begin
              grant1   = 1'b1;
              credit_d = '0;
            end
          end else if (elig0) begin
            grant0 = 1'b1;
          end else if (elig1) begin
            grant1   = 1'b1;
            credit_d = '0;
          end
          state_d = (grant0 || grant1) ? ST_ACTIVE : ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State, configuration and the registered pop / valid pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      weight_reg <= '0;
      credit     <= '0;
      pop_0      <= 1'b0;
      pop_1      <= 1'b0;
      valid_out  <= 1'b0;
      sel_out    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit    <= credit_d;
      pop_0     <= grant0;
      pop_1     <= grant1;
      valid_out <= pop_0 | pop_1;
      sel_out   <= pop_1;
      if (state_q == ST_INIT) weight_reg <= weight_in;
    end
  end

  assign state    = state_q;
  assign idle_out = (state_q == ST_IDLE);

`ifdef SCHED_STATS_EN
  // Counters are cleared on the edge entering INIT as well as while in INIT,
  // so they already read zero during the first INIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_count0 <= '0;
      pop_count1 <= '0;
    end else if (state_q == ST_INIT || state_d == ST_INIT) begin
      pop_count0 <= '0;
      pop_count1 <= '0;
    end else begin
      pop_count0 <= pop_count0 + {{(CNT_W-1){1'b0}}, pop_0};
      pop_count1 <= pop_count1 + {{(CNT_W-1){1'b0}}, pop_1};
    end
  end
`endif

endmodule

// File: tb/tb_pcie_pop_scheduler.sv
// tb_pcie_pop_scheduler
// Directed bench for pcie_pop_scheduler. Inputs change 1 time unit after a
// rising edge (or right after a falling edge); outputs are sampled on the
// falling edge or a few units after an asynchronous reset change.
module tb_pcie_pop_scheduler;

  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] weight_in;
  logic       fifo_empty0;
  logic       fifo_empty1;
  logic       fifo0_almost_empty;
  logic       fifo1_almost_empty;
  logic       fifo_up0_almostfull;
  logic       fifo_up1_almostfull;
  logic       pop_0;
  logic       pop_1;
  logic       valid_out;
  logic       sel_out;
  logic [2:0] state;
  logic       idle_out;
`ifdef SCHED_STATS_EN
  logic [15:0] pop_count0;
  logic [15:0] pop_count1;
`endif

  int checks = 0;
  int errors = 0;

  pcie_pop_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .init                (init),
    .weight_in           (weight_in),
    .fifo_empty0         (fifo_empty0),
    .fifo_empty1         (fifo_empty1),
    .fifo0_almost_empty  (fifo0_almost_empty),
    .fifo1_almost_empty  (fifo1_almost_empty),
    .fifo_up0_almostfull (fifo_up0_almostfull),
    .fifo_up1_almostfull (fifo_up1_almostfull),
    .pop_0               (pop_0),
    .pop_1               (pop_1),
    .valid_out           (valid_out),
    .sel_out             (sel_out),
    .state               (state),
    .idle_out            (idle_out)
`ifdef SCHED_STATS_EN
    , .pop_count0        (pop_count0)
    , .pop_count1        (pop_count1)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulse init with empty FIFOs and return to IDLE with weight w loaded.
  // Ends 1 unit after the edge that enters IDLE.
  task automatic do_init(input logic [3:0] w);
    @(posedge clk); #1;
    init                = 1'b1;
    weight_in           = w;
    fifo_empty0         = 1'b1;
    fifo_empty1         = 1'b1;
    fifo0_almost_empty  = 1'b0;
    fifo1_almost_empty  = 1'b0;
    fifo_up0_almostfull = 1'b0;
    fifo_up1_almostfull = 1'b0;
    @(posedge clk); #1;
    init = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reset held, then released with init=0 and weight_in=2: 0 -> 1 -> 2.
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset state: got %0d expected 0", state); end
    checks++;
    if ({pop_0, pop_1, valid_out, sel_out, idle_out} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset outputs: got %b expected 00000", {pop_0, pop_1, valid_out, sel_out, idle_out});
    end
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin errors++; $display("[TB] FAIL reset->init state: got %0d expected 1", state); end
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || idle_out !== 1'b1) begin
      errors++; $display("[TB] FAIL init->idle: got state %0d idle %b expected state 2 idle 1", state, idle_out);
    end
    checks++;
    if (pop_0 !== 1'b0 || pop_1 !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("[TB] FAIL idle no pops: got %b%b%b expected 000", pop_0, pop_1, valid_out);
    end
  endtask

  // weight=2, both FIFOs full: pops go 0,0,1 repeating; sel/valid lag one cycle.
  task automatic test_weighted();
    logic [8:0] pat1;
    pat1 = 9'b100100100;
    do_init(4'd2);
    fifo_empty0 = 1'b0;
    fifo_empty1 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (pop_0 !== ~pat1[i] || pop_1 !== pat1[i]) begin
        errors++; $display("[TB] FAIL weighted pop cycle %0d: got %b%b expected %b%b", i, pop_0, pop_1, ~pat1[i], pat1[i]);
      end
      checks++;
      if (valid_out !== (i > 0)) begin
        errors++; $display("[TB] FAIL weighted valid cycle %0d: got %b expected %b", i, valid_out, (i > 0));
      end
      if (i > 0) begin
        checks++;
        if (sel_out !== pat1[i-1]) begin
          errors++; $display("[TB] FAIL weighted sel cycle %0d: got %b expected %b", i, sel_out, pat1[i-1]);
        end
      end
      checks++;
      if (state !== 3'd3) begin errors++; $display("[TB] FAIL weighted state cycle %0d: got %0d expected 3", i, state); end
    end
    fifo_empty0 = 1'b1;
    fifo_empty1 = 1'b1;
  endtask

  // weight=0: strict P0 priority, P1 starved for 10 cycles.
  task automatic test_strict();
    do_init(4'd0);
    fifo_empty0 = 1'b0;
    fifo_empty1 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pop_0 !== 1'b1 || pop_1 !== 1'b0) begin
        errors++; $display("[TB] FAIL strict pop cycle %0d: got %b%b expected 10", i, pop_0, pop_1);
      end
    end
    fifo_empty0 = 1'b1;
    fifo_empty1 = 1'b1;
  endtask

  // Downstream almost-full on P0: only P1 pops; P0 resumes after release.
  task automatic test_backpressure();
    do_init(4'd2);
    fifo_empty0         = 1'b0;
    fifo_empty1         = 1'b0;
    fifo_up0_almostfull = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (pop_0 !== 1'b0 || pop_1 !== 1'b1) begin
        errors++; $display("[TB] FAIL backpressure pop cycle %0d: got %b%b expected 01", i, pop_0, pop_1);
      end
    end
    @(posedge clk); #1;
    fifo_up0_almostfull = 1'b0;
    @(negedge clk);
    checks++;
    if (pop_0 !== 1'b0 || pop_1 !== 1'b1) begin
      errors++; $display("[TB] FAIL backpressure release lag: got %b%b expected 01", pop_0, pop_1);
    end
    @(negedge clk);
    checks++;
    if (pop_0 !== 1'b1 || pop_1 !== 1'b0) begin
      errors++; $display("[TB] FAIL backpressure P0 resume: got %b%b expected 10", pop_0, pop_1);
    end
    fifo_empty0 = 1'b1;
    fifo_empty1 = 1'b1;
  endtask

  // FIFO0 holds its last word: exactly one pop, no second pop while empty lags.
  task automatic test_last_word();
    do_init(4'd2);
    fifo_empty0        = 1'b0;
    fifo0_almost_empty = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pop_0 !== 1'b1 || state !== 3'd3) begin
      errors++; $display("[TB] FAIL last word pop: got pop_0 %b state %0d expected 1 state 3", pop_0, state);
    end
    @(posedge clk); #1;
    fifo_empty0 = 1'b1;
    @(negedge clk);
    checks++;
    if (pop_0 !== 1'b0 || state !== 3'd2 || idle_out !== 1'b1) begin
      errors++; $display("[TB] FAIL last word no repop: got pop_0 %b state %0d idle %b expected 0 state 2 idle 1", pop_0, state, idle_out);
    end
    checks++;
    if (valid_out !== 1'b1 || sel_out !== 1'b0) begin
      errors++; $display("[TB] FAIL last word valid: got valid %b sel %b expected 1 0", valid_out, sel_out);
    end
    @(negedge clk);
    checks++;
    if (pop_0 !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("[TB] FAIL last word drained: got pop_0 %b valid %b expected 0 0", pop_0, valid_out);
    end
    fifo0_almost_empty = 1'b0;
  endtask

  // init during ACTIVE: pops stop, INIT next, credit restarts from zero.
  task automatic test_init_active();
    logic [2:0] pat1;
    pat1 = 3'b100;
    do_init(4'd2);
    fifo_empty0 = 1'b0;
    fifo_empty1 = 1'b0;
    @(posedge clk); #1;
    init = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd3) begin errors++; $display("[TB] FAIL init precondition state: got %0d expected 3", state); end
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || pop_0 !== 1'b0 || pop_1 !== 1'b0) begin
      errors++; $display("[TB] FAIL init entry: got state %0d pops %b%b expected state 1 pops 00", state, pop_0, pop_1);
    end
`ifdef SCHED_STATS_EN
    checks++;
    if (pop_count0 !== 16'd0 || pop_count1 !== 16'd0) begin
      errors++; $display("[TB] FAIL init counters: got %0d %0d expected 0 0", pop_count0, pop_count1);
    end
`endif
    @(posedge clk); #1;
    init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || pop_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL init exit: got state %0d pop_0 %b expected state 2 pop_0 0", state, pop_0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pop_0 !== ~pat1[i] || pop_1 !== pat1[i]) begin
        errors++; $display("[TB] FAIL init credit cycle %0d: got %b%b expected %b%b", i, pop_0, pop_1, ~pat1[i], pat1[i]);
      end
    end
    fifo_empty0 = 1'b1;
    fifo_empty1 = 1'b1;
  endtask

  // Asynchronous reset mid-transfer drops pops and valid immediately.
  task automatic test_async_reset();
    do_init(4'd2);
    fifo_empty0 = 1'b0;
    fifo_empty1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    checks++;
    if (pop_0 !== 1'b1 || valid_out !== 1'b1) begin
      errors++; $display("[TB] FAIL async precondition: got pop_0 %b valid %b expected 1 1", pop_0, valid_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({pop_0, pop_1, valid_out, sel_out, idle_out} !== 5'b0 || state !== 3'd0) begin
      errors++; $display("[TB] FAIL async reset: got outputs %b state %0d expected 00000 state 0", {pop_0, pop_1, valid_out, sel_out, idle_out}, state);
    end
    fifo_empty0 = 1'b1;
    fifo_empty1 = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd1) begin errors++; $display("[TB] FAIL async release INIT: got %0d expected 1", state); end
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd2) begin errors++; $display("[TB] FAIL async release IDLE: got %0d expected 2", state); end
  endtask

  // Scenario sequence.
  initial begin
    reset               = 1'b0;
    init                = 1'b0;
    weight_in           = 4'd2;
    fifo_empty0         = 1'b1;
    fifo_empty1         = 1'b1;
    fifo0_almost_empty  = 1'b0;
    fifo1_almost_empty  = 1'b0;
    fifo_up0_almostfull = 1'b0;
    fifo_up1_almostfull = 1'b0;
    $display("[TB] starting pcie_pop_scheduler bench");
    test_reset();
    test_weighted();
    test_strict();
    test_backpressure();
    test_last_word();
    test_init_active();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
